raster_timing_gen: RTL and testbench

- Free-running raster scan generator that drives the video side of the scanline buffer.
- Produces the current column/row, a per-line buffer-swap pulse and a per-frame pulse for the scanline buffer.
- Takes back the pixel intensity the buffer returns and emits VGA RGB with hsync/vsync, delayed to match the buffer's read latency.
- Sits between the scanline buffer and the board VGA connector.

---
 rtl/raster_timing_gen_if.sv | 30 +++
 rtl/raster_timing_gen.sv | 131 +++++++++++++
 tb/tb_raster_timing_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/raster_timing_gen_if.sv
// Signal bundle between raster_timing_gen, the scanline buffer and the VGA pins.
// The master side is the generator; the slave side is the buffer/connector.
interface raster_timing_gen_if #(
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 10,
    parameter int AGE_WIDTH = 8
);
    logic [X_WIDTH-1:0]   xout_o;
    logic [Y_WIDTH-1:0]   yout_o;
    logic                 newline_o;
    logic                 newframe_o;
    logic [AGE_WIDTH-1:0] pixel_i;
    logic [3:0]           vga_r_o;
    logic [3:0]           vga_g_o;
    logic [3:0]           vga_b_o;
    logic                 vga_hs_o;
    logic                 vga_vs_o;

    modport master (
        output xout_o, yout_o, newline_o, newframe_o,
        output vga_r_o, vga_g_o, vga_b_o, vga_hs_o, vga_vs_o,
        input  pixel_i
    );

    modport slave (
        input  xout_o, yout_o, newline_o, newframe_o,
        input  vga_r_o, vga_g_o, vga_b_o, vga_hs_o, vga_vs_o,
        output pixel_i
    );
endinterface

// File: rtl/raster_timing_gen.sv
// Free-running raster scan: drives column/row and line/frame pulses to the scanline
// buffer, then turns the returned intensity into latency-aligned VGA RGB and syncs.
module raster_timing_gen #(
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 10,
    parameter int AGE_WIDTH = 8,
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIX_LAT   = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    raster_timing_gen_if.master bus
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam bit PARAMS_OK = (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                               (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1) &&
                               (H_ACTIVE <= (1 << X_WIDTH)) && (V_ACTIVE <= (1 << Y_WIDTH)) &&
                               (PIX_LAT >= 1) && (PIX_LAT <= 4) && (AGE_WIDTH >= 4);

    logic [HW-1:0]      r_hcnt;
    logic [VW-1:0]      r_vcnt;
    logic               w_hact, w_vact, w_de, w_hs_act, w_vs_act;
    logic               w_unused_pix;
    logic [X_WIDTH-1:0] r_xout;
    logic [Y_WIDTH-1:0] r_yout;
    logic               r_newline, r_newframe;
    logic [PIX_LAT:0]   r_de_pipe, r_hs_pipe, r_vs_pipe;
    logic [3:0]         r_r, r_g, r_b;
    logic               r_hs, r_vs;

    always @(posedge clk_i) begin
        assert (PARAMS_OK) else $error("raster_timing_gen: illegal timing parameters");
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    assign w_hact   = r_hcnt < H_ACT_C;
    assign w_vact   = r_vcnt < V_ACT_C;
    assign w_de     = w_hact & w_vact;
    assign w_hs_act = (r_hcnt >= H_SS_C) && (r_hcnt < H_SE_C);
    assign w_vs_act = (r_vcnt >= V_SS_C) && (r_vcnt < V_SE_C);

    // Stage 0 of each region pipe lines up with r_xout; stage PIX_LAT with pixel_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_xout     <= '0;
            r_yout     <= '0;
            r_newline  <= 1'b0;
            r_newframe <= 1'b0;
            r_de_pipe  <= '0;
            r_hs_pipe  <= '0;
            r_vs_pipe  <= '0;
        end else begin
            r_xout     <= w_de ? X_WIDTH'(r_hcnt) : '0;
            r_yout     <= w_vact ? Y_WIDTH'(r_vcnt) : '0;
            // Fires on vblank lines too so the buffer's swap parity stays fixed.
            r_newline  <= (r_hcnt == H_ACT_C);
            r_newframe <= (r_vcnt == V_ACT_C) && (r_hcnt == '0);
            r_de_pipe  <= {r_de_pipe[PIX_LAT-1:0], w_de};
            r_hs_pipe  <= {r_hs_pipe[PIX_LAT-1:0], w_hs_act};
            r_vs_pipe  <= {r_vs_pipe[PIX_LAT-1:0], w_vs_act};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
        end else begin
            if (r_de_pipe[PIX_LAT]) begin
                r_r <= {1'b0, bus.pixel_i[AGE_WIDTH-1 -: 3]};
                r_g <= bus.pixel_i[AGE_WIDTH-1 -: 4];
                r_b <= bus.pixel_i[AGE_WIDTH-1 -: 4];
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
            r_hs <= r_hs_pipe[PIX_LAT] ? HS_POL : ~HS_POL;
            r_vs <= r_vs_pipe[PIX_LAT] ? VS_POL : ~VS_POL;
        end
    end

    // Only the top bits of the intensity reach the DAC.
    assign w_unused_pix = ^bus.pixel_i;

    assign bus.xout_o     = r_xout;
    assign bus.yout_o     = r_yout;
    assign bus.newline_o  = r_newline;
    assign bus.newframe_o = r_newframe;
    assign bus.vga_r_o    = r_r;
    assign bus.vga_g_o    = r_g;
    assign bus.vga_b_o    = r_b;
    assign bus.vga_hs_o   = r_hs;
    assign bus.vga_vs_o   = r_vs;
endmodule

// File: tb/tb_raster_timing_gen.sv
// Bench for raster_timing_gen on a small raster (H 8/2/2/2, V 4/1/1/1): instance A
// at PIX_LAT=1 with low syncs, instance B at PIX_LAT=3 with an active-high hsync.
module tb_raster_timing_gen;
    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2, HT = HA + HFP + HSY + HBP;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1, VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    raster_timing_gen_if #(.X_WIDTH(4), .Y_WIDTH(3), .AGE_WIDTH(8)) ifa ();
    raster_timing_gen_if #(.X_WIDTH(4), .Y_WIDTH(3), .AGE_WIDTH(8)) ifb ();

    raster_timing_gen #(
        .X_WIDTH(4), .Y_WIDTH(3), .AGE_WIDTH(8),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(1)
    ) u_dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa));

    raster_timing_gen #(
        .X_WIDTH(4), .Y_WIDTH(3), .AGE_WIDTH(8),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIX_LAT(3)
    ) u_dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    function automatic logic [7:0] pixf(input logic [3:0] x);
        return 8'((int'(x) * 37 + 11) & 255);
    endfunction

    // Scanline buffer stand-in: returns pixf(column) PIX_LAT clocks after xout_o.
    logic [3:0]      pipe_a = '0;
    logic [2:0][3:0] pipe_b = '0;
    always @(posedge clk) begin
        pipe_a <= ifa.xout_o;
        pipe_b <= {pipe_b[1:0], ifb.xout_o};
    end
    assign ifa.pixel_i = pixf(pipe_a);
    assign ifb.pixel_i = pixf(pipe_b[2]);

    // Expected {xout, yout, newline, newframe} after the n-th edge since release.
    function automatic logic [8:0] exp_timing(input int n);
        int c, h, v;
        c = n - 1; h = c % HT; v = (c / HT) % VT;
        return {4'((h < HA && v < VA) ? h : 0), 3'((v < VA) ? v : 0),
                1'(h == HA), 1'(v == VA && h == 0)};
    endfunction

    // Expected {r, g, b, hs, vs} for the scan position cv (negative = still in reset fill).
    function automatic logic [13:0] exp_video(input int cv, input bit hp, input bit vp);
        int h, v;
        logic [7:0] p;
        logic [13:0] r;
        if (cv < 0) return {12'h000, ~hp, ~vp};
        h = cv % HT; v = (cv / HT) % VT;
        p = pixf(4'(h));
        r[13:2] = (h < HA && v < VA) ? {1'b0, p[7:5], p[7:4], p[7:4]} : 12'h000;
        r[1] = (h >= HA + HFP && h < HA + HFP + HSY) ? hp : ~hp;
        r[0] = (v >= VA + VFP && v < VA + VFP + VSY) ? vp : ~vp;
        return r;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o} !== 9'h0) begin
            fails++; $display("FAIL reset_timing_a got %h want 000", {ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o});
        end
        tests++;
        if ({ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o} !== 14'h0003) begin
            fails++; $display("FAIL reset_video_a got %h want 0003", {ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o});
        end
        tests++;
        if ({ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o} !== 14'h0001) begin
            fails++; $display("FAIL reset_video_b got %h want 0001", {ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o});
        end
    endtask

    // Hand-derived checkpoints for the first frame after release.
    task automatic test_first_line;
        int          tn[11] = '{1, 2, 8, 9, 15, 22, 57, 65, 98, 99, 100};
        logic [8:0]  tx[11] = '{{4'd0, 3'd0, 2'b00}, {4'd1, 3'd0, 2'b00}, {4'd7, 3'd0, 2'b00},
                                {4'd0, 3'd0, 2'b10}, {4'd0, 3'd1, 2'b00}, {4'd7, 3'd1, 2'b00},
                                {4'd0, 3'd0, 2'b01}, {4'd0, 3'd0, 2'b10}, {4'd0, 3'd0, 2'b00},
                                {4'd0, 3'd0, 2'b00}, {4'd1, 3'd0, 2'b00}};
        int          vn[9]  = '{3, 4, 9, 10, 11, 13, 15, 72, 73};
        logic [13:0] vx[9]  = '{14'h0003, {12'h133, 2'b11}, {12'h7EE, 2'b11}, 14'h0003,
                                14'h0003, 14'h0001, 14'h0003, 14'h0003, 14'h0002};
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            for (int i = 0; i < 11; i++) if (tn[i] == n) begin
                tests++;
                if ({ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o} !== tx[i]) begin
                    fails++; $display("FAIL first_timing n=%0d got %h want %h", n, {ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o}, tx[i]);
                end
            end
            for (int i = 0; i < 9; i++) if (vn[i] == n) begin
                tests++;
                if ({ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o} !== vx[i]) begin
                    fails++; $display("FAIL first_video n=%0d got %h want %h", n, {ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o}, vx[i]);
                end
            end
            if (n == 11) begin
                tests++;
                if ({ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o} !== {12'h7EE, 2'b01}) begin
                    fails++; $display("FAIL first_video_b n=11 got %h want 1fb9", {ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o});
                end
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the counter model; must start right at release.
    task automatic test_scan(input int frames);
        logic [8:0]  et;
        logic [13:0] ea, eb;
        for (int n = 1; n <= frames * FR; n++) begin
            @(negedge clk);
            et = exp_timing(n);
            ea = exp_video(n - 3, 1'b0, 1'b0);
            eb = exp_video(n - 5, 1'b1, 1'b0);
            tests++;
            if ({ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o} !== et) begin
                fails++; $display("FAIL scan_timing_a n=%0d got %h want %h", n, {ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o}, et);
            end
            tests++;
            if ({ifb.xout_o, ifb.yout_o, ifb.newline_o, ifb.newframe_o} !== et) begin
                fails++; $display("FAIL scan_timing_b n=%0d got %h want %h", n, {ifb.xout_o, ifb.yout_o, ifb.newline_o, ifb.newframe_o}, et);
            end
            tests++;
            if ({ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o} !== ea) begin
                fails++; $display("FAIL scan_video_a n=%0d got %h want %h", n, {ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_hs_o, ifa.vga_vs_o}, ea);
            end
            tests++;
            if ({ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o} !== eb) begin
                fails++; $display("FAIL scan_video_b n=%0d got %h want %h", n, {ifb.vga_r_o, ifb.vga_g_o, ifb.vga_b_o, ifb.vga_hs_o, ifb.vga_vs_o}, eb);
            end
        end
    endtask

    task automatic test_sync_timing;
        int hf[$], hr[$], vf[$], vr[$];
        int nl = 0, nf = 0, both = 0, dbl = 0, hw = -1, vw = -1;
        logic phs, pvs, pnl;
        phs = ifa.vga_hs_o; pvs = ifa.vga_vs_o; pnl = ifa.newline_o;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phs && !ifa.vga_hs_o) hf.push_back(i);
            if (!phs && ifa.vga_hs_o) hr.push_back(i);
            if (pvs && !ifa.vga_vs_o) vf.push_back(i);
            if (!pvs && ifa.vga_vs_o) vr.push_back(i);
            if (i < FR) begin
                if (ifa.newline_o) nl++;
                if (ifa.newframe_o) nf++;
            end
            if (ifa.newline_o && ifa.newframe_o) both++;
            if (ifa.newline_o && pnl) dbl++;
            phs = ifa.vga_hs_o; pvs = ifa.vga_vs_o; pnl = ifa.newline_o;
        end
        tests++;
        if (hf.size() < 2 || vf.size() < 2) begin
            fails++; $display("FAIL sync_edges got hfall=%0d vfall=%0d want >=2 each", hf.size(), vf.size());
        end else begin
            foreach (hr[i]) if (hw < 0 && hr[i] > hf[0]) hw = hr[i] - hf[0];
            foreach (vr[i]) if (vw < 0 && vr[i] > vf[0]) vw = vr[i] - vf[0];
            tests++;
            if (hw != HSY) begin fails++; $display("FAIL hs_width got %0d want %0d", hw, HSY); end
            tests++;
            if (hf[1] - hf[0] != HT) begin fails++; $display("FAIL hs_period got %0d want %0d", hf[1] - hf[0], HT); end
            tests++;
            if (vw != VSY * HT) begin fails++; $display("FAIL vs_width got %0d want %0d", vw, VSY * HT); end
            tests++;
            if (vf[1] - vf[0] != FR) begin fails++; $display("FAIL vs_period got %0d want %0d", vf[1] - vf[0], FR); end
        end
        tests++;
        if (nl != VT) begin fails++; $display("FAIL newline_count got %0d want %0d", nl, VT); end
        tests++;
        if (nf != 1) begin fails++; $display("FAIL newframe_count got %0d want 1", nf); end
        tests++;
        if (both != 0 || dbl != 0) begin fails++; $display("FAIL pulse_shape got coincident=%0d wide=%0d want 0/0", both, dbl); end
    endtask

    task automatic test_async_reset;
        int k = 0;
        while (ifa.vga_hs_o !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        tests++;
        if (ifa.vga_hs_o !== 1'b0) begin fails++; $display("FAIL hs_reach got %b want 0", ifa.vga_hs_o); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (ifa.vga_hs_o !== 1'b1) begin fails++; $display("FAIL async_hs got %b want 1", ifa.vga_hs_o); end
        tests++;
        if ({ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o, ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_vs_o} !== 22'h000001) begin
            fails++; $display("FAIL async_outs_a got %h want 000001", {ifa.xout_o, ifa.yout_o, ifa.newline_o, ifa.newframe_o, ifa.vga_r_o, ifa.vga_g_o, ifa.vga_b_o, ifa.vga_vs_o});
        end
        tests++;
        if ({ifb.vga_hs_o, ifb.vga_vs_o} !== 2'b01) begin
            fails++; $display("FAIL async_sync_b got %b want 01", {ifb.vga_hs_o, ifb.vga_vs_o});
        end
        @(negedge clk);
        tests++;
        if ({ifa.xout_o, ifa.newline_o, ifa.vga_hs_o} !== 6'b000001) begin
            fails++; $display("FAIL held_reset got %b want 000001", {ifa.xout_o, ifa.newline_o, ifa.vga_hs_o});
        end
        rst_n = 1'b1;
        test_scan(1);
    endtask

    initial begin
        test_reset();
        rst_n = 1'b1;
        test_first_line();
        do_reset();
        test_scan(3);
        test_sync_timing();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
